// File: rtl/mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_sb
// Purpose  : Parametrised MIPS register file with write-to-read bypass,
//            per-register pending scoreboard and a reset-triggered clear sweep.
// Revision : 1.0 - initial release
// ============================================================================
module mips_regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int BYPASS = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    output logic              ready
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] c_last_addr = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [ADDR_W-1:0]   r_clr_cnt;
    logic [ADDR_W-1:0]   w_clr_cnt_next;
    logic                w_clr_en;
    logic                r_ready;
    logic                w_wr_fire;
    logic [DATA_W-1:0]   r_mem [DEPTH];
    logic [DEPTH-1:0]    r_pend;
    logic [DEPTH-1:0]    w_pend_next;
    logic [ADDR_W-1:0]   w_rd_addr [2];

    // ------------------------------------------------------------------
    // Clear-sweep FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_clr_cnt <= w_clr_cnt_next;
            r_ready   <= (w_state_next == ST_RUN);
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_cnt_next = r_clr_cnt;
        w_clr_en       = 1'b0;
        case (r_state)
            ST_CLEAR: begin
                w_clr_en = 1'b1;
                if (r_clr_cnt == c_last_addr) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_clr_cnt_next = r_clr_cnt + 1'b1;
                end
            end
            ST_RUN: begin
                w_state_next = ST_RUN;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    assign ready     = r_ready;
    assign w_wr_fire = r_ready && wr_en && (wr_addr != '0);

    // ------------------------------------------------------------------
    // Storage array; the sweep only runs while ready is low, so it never
    // competes with a functional write.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (w_clr_en) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_wr_fire) begin
                r_mem[wr_addr] <= wr_data;
            end
        end
    end

    // Set is applied after clear so a new producer overrides a completing one
    always_comb begin
        w_pend_next = r_pend;
        if (r_ready) begin
            if (wr_en && (wr_addr != '0)) begin
                w_pend_next[wr_addr] = 1'b0;
            end
            if (busy_set && (busy_addr != '0)) begin
                w_pend_next[busy_addr] = 1'b1;
            end
        end
        w_pend_next[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_pend <= '0;
        end else begin
            r_pend <= w_pend_next;
        end
    end

    // ------------------------------------------------------------------
    // Read ports
    // ------------------------------------------------------------------
    assign w_rd_addr[0] = rd_addr1;
    assign w_rd_addr[1] = rd_addr2;

    for (genvar p = 0; p < 2; p++) begin : g_rd_port
        logic              w_hit;
        logic [DATA_W-1:0] w_data;
        logic              w_busy;

        assign w_hit = (BYPASS != 0) && r_ready && wr_en && (wr_addr == w_rd_addr[p]);

        always_comb begin
            w_data = '0;
            w_busy = 1'b0;
            if (r_ready && (w_rd_addr[p] != '0)) begin
                if (w_hit) begin
                    w_data = wr_data;
                end else begin
                    w_data = r_mem[w_rd_addr[p]];
                    w_busy = r_pend[w_rd_addr[p]];
                end
            end
        end
    end

    assign rd_data1 = g_rd_port[0].w_data;
    assign rd_data2 = g_rd_port[1].w_data;
    assign rd_busy1 = g_rd_port[0].w_busy;
    assign rd_busy2 = g_rd_port[1].w_busy;

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_sb
// Purpose  : Self-checking bench for mips_regfile_sb (bypass and non-bypass).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mips_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, busy_addr;
    logic        wr_en, busy_set;
    logic [31:0] wr_data;

    logic [31:0] b_rd1, b_rd2, n_rd1, n_rd2;
    logic        b_busy1, b_busy2, n_busy1, n_busy2, b_ready, n_ready;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference state: architectural register contents and scoreboard
    logic [31:0] m_mem [32];
    bit          m_pend [32];
    bit          m_ready = 1'b0;
    int          m_swept = 0;

    always #5 clk = ~clk;

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(1)) u_byp (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(b_rd1), .rd_data2(b_rd2),
        .rd_busy1(b_busy1), .rd_busy2(b_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .ready(b_ready)
    );

    mips_regfile_sb #(.DATA_W(32), .ADDR_W(5), .BYPASS(0)) u_nob (
        .clk(clk), .rst(rst),
        .rd_addr1(rd_addr1), .rd_addr2(rd_addr2),
        .rd_data1(n_rd1), .rd_data2(n_rd2),
        .rd_busy1(n_busy1), .rd_busy2(n_busy2),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy_set(busy_set), .busy_addr(busy_addr),
        .ready(n_ready)
    );

    typedef struct {
        logic [4:0]  rd1;
        logic [4:0]  rd2;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        bs;
        logic [4:0]  ba;
        logic [31:0] e1;
        logic [31:0] e2;
        logic        eb1;
        logic        eb2;
    } vec_t;

    vec_t tbl [15];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chkb(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] a, input bit byp);
        if (!m_ready || a == 5'd0) return 32'h0;
        if (byp && wr_en && wr_addr == a) return wr_data;
        return m_mem[a];
    endfunction

    function automatic logic m_busy(input logic [4:0] a, input bit byp);
        if (!m_ready || a == 5'd0) return 1'b0;
        if (byp && wr_en && wr_addr == a) return 1'b0;
        return m_pend[a];
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_ready = 1'b0;
            m_swept = 0;
            for (int i = 0; i < 32; i++) m_pend[i] = 1'b0;
        end else if (!m_ready) begin
            m_mem[m_swept] = 32'h0;
            m_swept++;
            if (m_swept == 32) m_ready = 1'b1;
        end else begin
            if (wr_en && wr_addr != 5'd0) begin
                m_mem[wr_addr]  = wr_data;
                m_pend[wr_addr] = 1'b0;
            end
            if (busy_set && busy_addr != 5'd0) m_pend[busy_addr] = 1'b1;
        end
    endtask

    task automatic cmp_all();
        chkb("byp_ready", b_ready, m_ready);
        chk ("byp_rd1",   b_rd1,   m_rd(rd_addr1, 1'b1));
        chk ("byp_rd2",   b_rd2,   m_rd(rd_addr2, 1'b1));
        chkb("byp_busy1", b_busy1, m_busy(rd_addr1, 1'b1));
        chkb("byp_busy2", b_busy2, m_busy(rd_addr2, 1'b1));
        chkb("nob_ready", n_ready, m_ready);
        chk ("nob_rd1",   n_rd1,   m_rd(rd_addr1, 1'b0));
        chk ("nob_rd2",   n_rd2,   m_rd(rd_addr2, 1'b0));
        chkb("nob_busy1", n_busy1, m_busy(rd_addr1, 1'b0));
        chkb("nob_busy2", n_busy2, m_busy(rd_addr2, 1'b0));
    endtask

    // Check this cycle's outputs, then take one clock edge
    task automatic cyc();
        #1;
        cmp_all();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic wait_sweep(input string name);
        int edges = 0;
        while (b_ready !== 1'b1 && edges < 64) begin
            cyc();
            edges++;
        end
        chk(name, 32'(edges), 32'd32);
    endtask

    task automatic idle();
        wr_en = 1'b0; busy_set = 1'b0;
        wr_addr = 5'd0; busy_addr = 5'd0; wr_data = 32'h0;
        rd_addr1 = 5'd0; rd_addr2 = 5'd0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{5'd8,  5'd0,  1'b1, 5'd8,  32'h12345678, 1'b0, 5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0};
        tbl[1]  = '{5'd8,  5'd0,  1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h12345678, 32'h0,        1'b0, 1'b0};
        tbl[2]  = '{5'd8,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd10, 32'h12345678, 32'h0,        1'b0, 1'b0};
        tbl[3]  = '{5'd10, 5'd0,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0,        1'b1, 1'b0};
        tbl[4]  = '{5'd10, 5'd10, 1'b1, 5'd10, 32'h0000AAAA, 1'b0, 5'd0,  32'h0000AAAA, 32'h0000AAAA, 1'b0, 1'b0};
        tbl[5]  = '{5'd10, 5'd8,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0000AAAA, 32'h12345678, 1'b0, 1'b0};
        tbl[6]  = '{5'd10, 5'd0,  1'b1, 5'd10, 32'h0000BBBB, 1'b1, 5'd10, 32'h0000BBBB, 32'h0,        1'b0, 1'b0};
        tbl[7]  = '{5'd10, 5'd10, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0000BBBB, 32'h0000BBBB, 1'b1, 1'b1};
        tbl[8]  = '{5'd0,  5'd0,  1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  32'h0,        32'h0,        1'b0, 1'b0};
        tbl[9]  = '{5'd0,  5'd10, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        32'h0000BBBB, 1'b0, 1'b1};
        tbl[10] = '{5'd9,  5'd9,  1'b1, 5'd9,  32'h1,        1'b0, 5'd0,  32'h1,        32'h1,        1'b0, 1'b0};
        tbl[11] = '{5'd9,  5'd9,  1'b1, 5'd9,  32'h2,        1'b0, 5'd0,  32'h2,        32'h2,        1'b0, 1'b0};
        tbl[12] = '{5'd9,  5'd9,  1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h2,        32'h2,        1'b0, 1'b0};
        tbl[13] = '{5'd10, 5'd20, 1'b1, 5'd10, 32'h0000CCCC, 1'b1, 5'd20, 32'h0000CCCC, 32'h0,        1'b0, 1'b0};
        tbl[14] = '{5'd10, 5'd20, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0000CCCC, 32'h0,        1'b0, 1'b1};

        for (int i = 0; i < 32; i++) begin
            m_mem[i]  = 32'h0;
            m_pend[i] = 1'b0;
        end

        idle();
        rst = 1'b1;
        @(negedge clk);
        @(posedge clk);
        model_edge();
        @(negedge clk);
        cyc();
        rst = 1'b0;
        wait_sweep("init_sweep_len");

        // Sweep wipes preloaded data; writes held during the sweep are ignored
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h0000DEAD; rd_addr1 = 5'd5;
        cyc();
        wr_en = 1'b0;
        #1 chk("preload_rd", b_rd1, 32'h0000DEAD);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'h7;
        wait_sweep("sweep_len");
        wr_en = 1'b0;
        #1;
        chk("swept_reg5", b_rd1, 32'h0);
        chk("swept_reg5_nob", n_rd1, 32'h0);

        // Reset on sweep edge 10 restarts the count
        idle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (9) cyc();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        wait_sweep("restart_sweep_len");

        for (int i = 0; i < 15; i++) begin
            rd_addr1 = tbl[i].rd1; rd_addr2 = tbl[i].rd2;
            wr_en = tbl[i].we; wr_addr = tbl[i].wa; wr_data = tbl[i].wd;
            busy_set = tbl[i].bs; busy_addr = tbl[i].ba;
            #1;
            chk ($sformatf("vec%0d_rd1", i),   b_rd1,   tbl[i].e1);
            chk ($sformatf("vec%0d_rd2", i),   b_rd2,   tbl[i].e2);
            chkb($sformatf("vec%0d_busy1", i), b_busy1, tbl[i].eb1);
            chkb($sformatf("vec%0d_busy2", i), b_busy2, tbl[i].eb2);
            if (i == 11) chk("nobyp_same_cycle", n_rd1, 32'h1);
            if (i == 12) chk("nobyp_next_cycle", n_rd2, 32'h2);
            cyc();
        end

        // Reset clears pending bits immediately and they stay clear
        idle();
        busy_set = 1'b1; busy_addr = 5'd3;
        cyc();
        busy_addr = 5'd31;
        cyc();
        busy_set = 1'b0; rd_addr1 = 5'd3; rd_addr2 = 5'd31;
        #1;
        chkb("pend3_set", b_busy1, 1'b1);
        chkb("pend31_set", b_busy2, 1'b1);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        #1;
        chkb("pend3_after_rst", b_busy1, 1'b0);
        chkb("pend31_after_rst", b_busy2, 1'b0);
        wait_sweep("pend_sweep_len");
        #1;
        chkb("pend3_after_sweep", b_busy1, 1'b0);
        chkb("pend31_after_sweep", b_busy2, 1'b0);

        for (int c = 0; c < 1500; c++) begin
            rst       = ($urandom_range(0, 199) == 0);
            wr_en     = 1'($urandom_range(0, 1));
            wr_addr   = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            wr_data   = $urandom();
            busy_set  = ($urandom_range(0, 4) < 2);
            busy_addr = 5'($urandom_range(0, 7));
            rd_addr1  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 7));
            rd_addr2  = ($urandom_range(0, 3) == 0) ? wr_addr : 5'($urandom_range(0, 31));
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
